// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl
// Scans NUM_CH channels of a parallel ADC once per frame and writes each packed
// frame into a DEPTH-entry sample RAM. Supports single-shot and continuous ring
// capture, frame decimation, an EOC timeout and sticky overrun detection.
// All ADC strobes and status outputs are registered and decoded from the next
// FSM state, so they change cleanly on the clock edge and reset asynchronously.
module adc_capture_ctrl #(
    parameter int DATA_W       = 8,
    parameter int NUM_CH       = 4,
    parameter int ADDR_W       = 9,
    parameter int FRAME_PERIOD = 1250,
    parameter int CONVST_CYC   = 2,
    parameter int RD_CYC       = 3,
    parameter int EOC_TIMEOUT  = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [2:0]               chnl,
    output logic                     n_convst,
    input  logic                     n_eoc,
    output logic                     n_cs,
    output logic                     n_rd,
    input  logic [DATA_W-1:0]        adc_in,
    input  logic                     start,
    input  logic                     continuous,
    input  logic [3:0]               decim,
    output logic [ADDR_W-1:0]        w_addr,
    output logic [NUM_CH*DATA_W-1:0] w_data,
    output logic                     wren,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun,
    output logic                     eoc_err
);

    localparam int           CNT_W   = 16;
    localparam int           TMR_W   = $clog2(FRAME_PERIOD);
    localparam logic [2:0]   LAST_CH = 3'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_WAIT_EOC,
        S_READ,
        S_NEXT,
        S_WRITE,
        S_WAIT_TICK,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [2:0]              r_chnl;
    logic                    r_start_prev;
    logic                    r_cont;
    logic [3:0]              r_decim;
    logic [3:0]              r_dcnt;
    logic [TMR_W-1:0]        r_timer;
    logic [ADDR_W-1:0]       r_addr;
    logic [NUM_CH*DATA_W-1:0] r_data;
    logic                    r_wren;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_overrun;
    logic                    r_eoc_err;
    logic                    r_n_convst;
    logic                    r_n_cs;
    logic                    r_n_rd;

    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [2:0]              w_chnl_nxt;
    logic [3:0]              w_dcnt_nxt;
    logic                    w_arm;
    logic                    w_do_write;
    logic                    w_timeout;
    logic                    w_latch;
    logic                    w_tick;
    logic                    w_busy_nxt;

    assign chnl     = r_chnl;
    assign n_convst = r_n_convst;
    assign n_cs     = r_n_cs;
    assign n_rd     = r_n_rd;
    assign w_addr   = r_addr;
    assign w_data   = r_data;
    assign wren     = r_wren;
    assign busy     = r_busy;
    assign done     = r_done;
    assign overrun  = r_overrun;
    assign eoc_err  = r_eoc_err;

    // Frame tick: the free-running frame timer is about to wrap.
    assign w_tick = r_busy && (r_timer == TMR_W'(FRAME_PERIOD - 1));

    // Next-state and per-state control decisions for the capture sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_chnl_nxt  = r_chnl;
        w_dcnt_nxt  = r_dcnt;
        w_arm       = 1'b0;
        w_do_write  = 1'b0;
        w_timeout   = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !r_start_prev) begin
                    w_arm       = 1'b1;
                    w_state_nxt = S_CONV;
                    w_cnt_nxt   = '0;
                    w_chnl_nxt  = 3'd0;
                    w_dcnt_nxt  = 4'd0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CONV: begin
                if (r_cnt == CNT_W'(CONVST_CYC - 1)) begin
                    w_state_nxt = S_WAIT_EOC;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_WAIT_EOC: begin
                if (!n_eoc) begin
                    w_state_nxt = S_READ;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_W'(EOC_TIMEOUT - 1)) begin
                    w_state_nxt = S_DONE;
                    w_timeout   = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_READ: begin
                if (r_cnt == CNT_W'(RD_CYC - 1)) begin
                    // Data is captured on the last cycle of the read strobe.
                    w_latch     = 1'b1;
                    w_state_nxt = S_NEXT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_NEXT: begin
                if (r_chnl == LAST_CH) begin
                    w_state_nxt = S_WRITE;
                end else begin
                    w_chnl_nxt  = r_chnl + 3'd1;
                    w_state_nxt = S_CONV;
                end
            end
            S_WRITE: begin
                if (r_dcnt == r_decim) begin
                    w_do_write = 1'b1;
                    w_dcnt_nxt = 4'd0;
                    // Single-shot ends after the write to the last RAM entry.
                    if (!r_cont && (r_addr == {ADDR_W{1'b1}})) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_WAIT_TICK;
                    end
                end else begin
                    w_dcnt_nxt  = r_dcnt + 4'd1;
                    w_state_nxt = S_WAIT_TICK;
                end
            end
            S_WAIT_TICK: begin
                if (r_cont && !start) begin
                    w_state_nxt = S_DONE;
                end else if (w_tick) begin
                    w_chnl_nxt  = 3'd0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_CONV;
                end else begin
                    w_state_nxt = S_WAIT_TICK;
                end
            end
            S_DONE: begin
                if (!start) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
    end

    // FSM state, sequencing counter and channel register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_chnl       <= 3'd0;
            r_start_prev <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_chnl       <= w_chnl_nxt;
            r_start_prev <= start;
        end
    end

    // Arm-time configuration latch, decimation counter and frame timer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cont  <= 1'b0;
            r_decim <= 4'd0;
            r_dcnt  <= 4'd0;
            r_timer <= '0;
        end else begin
            if (w_arm) begin
                r_cont  <= continuous;
                r_decim <= decim;
            end
            r_dcnt <= w_dcnt_nxt;
            if (w_arm || !r_busy || w_tick) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TMR_W'(1);
            end
        end
    end

    // ADC strobes and status flags, decoded from the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_n_convst <= 1'b1;
            r_n_cs     <= 1'b1;
            r_n_rd     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wren     <= 1'b0;
        end else begin
            r_n_convst <= (w_state_nxt != S_CONV);
            r_n_cs     <= (w_state_nxt != S_READ);
            r_n_rd     <= (w_state_nxt != S_READ);
            r_busy     <= w_busy_nxt;
            r_done     <= (w_state_nxt == S_DONE);
            r_wren     <= w_do_write;
        end
    end

    // Sticky error flags; both are cleared when a new capture is armed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun <= 1'b0;
            r_eoc_err <= 1'b0;
        end else if (w_arm) begin
            r_overrun <= 1'b0;
            r_eoc_err <= 1'b0;
        end else begin
            if (w_tick && (r_state != S_WAIT_TICK)) begin
                r_overrun <= 1'b1;
            end
            if (w_timeout) begin
                r_eoc_err <= 1'b1;
            end
        end
    end

    // RAM write address: restarts at arm, advances the cycle after each write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr <= '0;
        end else if (w_arm) begin
            r_addr <= '0;
        end else if (r_wren) begin
            r_addr <= r_addr + ADDR_W'(1);
        end
    end

    // Frame data lanes: only the lane of the channel being read is updated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_latch && (r_chnl == 3'(k))) begin
                    r_data[k*DATA_W +: DATA_W] <= adc_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Testbench for adc_capture_ctrl: behavioural ADC model plus a write scoreboard.
// The ADC model answers the conversion handshake with random data, assembles
// the frames it has delivered and, from the decimation rule, pushes the write
// each completed frame must produce; a separate monitor pops on every wren.
module tb_adc_capture_ctrl;

    localparam int DW    = 8;
    localparam int NCH   = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int FP    = 64;
    localparam int CC    = 2;
    localparam int RC    = 3;
    localparam int TO    = 255;

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        chnl;
    logic              n_convst;
    logic              n_eoc;
    logic              n_cs;
    logic              n_rd;
    logic [DW-1:0]     adc_in;
    logic              start;
    logic              continuous;
    logic [3:0]        decim;
    logic [AW-1:0]     w_addr;
    logic [NCH*DW-1:0] w_data;
    logic              wren;
    logic              busy;
    logic              done;
    logic              overrun;
    logic              eoc_err;

    adc_capture_ctrl #(
        .DATA_W(DW), .NUM_CH(NCH), .ADDR_W(AW), .FRAME_PERIOD(FP),
        .CONVST_CYC(CC), .RD_CYC(RC), .EOC_TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .chnl(chnl), .n_convst(n_convst),
        .n_eoc(n_eoc), .n_cs(n_cs), .n_rd(n_rd), .adc_in(adc_in),
        .start(start), .continuous(continuous), .decim(decim),
        .w_addr(w_addr), .w_data(w_data), .wren(wren), .busy(busy),
        .done(done), .overrun(overrun), .eoc_err(eoc_err)
    );

    typedef struct {
        logic [AW-1:0]     addr;
        logic [NCH*DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_wr     = 0;

    // ADC behaviour selected by the stimulus: 0 random EOC, 1 fixed, 2 stuck
    int eoc_mode    = 0;
    int eoc_fix     = 3;
    int spacing_on  = 0;
    int spacing_exp = 0;
    int m_convst_rise_cyc = 0;

    function automatic void chk(input bit ok, input string name,
                                input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endfunction

    initial begin
        forever #5 clk = ~clk;
    end

    // Free cycle counter used for latency and spacing measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model and expected-write generator.
    initial begin : adc_model
        int          m_wait;
        int          m_conv_idx;
        int          m_wr_cnt;
        int          frame_no;
        logic        m_convst_prev;
        logic        m_rd_prev;
        logic        m_busy_prev;
        logic [NCH*DW-1:0] m_frame;
        m_wait = 0; m_conv_idx = 0; m_wr_cnt = 0;
        m_convst_prev = 1'b1; m_rd_prev = 1'b1; m_busy_prev = 1'b0;
        m_frame = '0;
        n_eoc = 1'b1;
        adc_in = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                n_eoc = 1'b1;
                m_wait = 0; m_conv_idx = 0; m_wr_cnt = 0;
                m_convst_prev = 1'b1; m_rd_prev = 1'b1; m_busy_prev = 1'b0;
                exp_q.delete();
            end else begin
                if (busy && !m_busy_prev) begin
                    m_conv_idx = 0;
                    m_wr_cnt = 0;
                end
                if (!n_convst && m_convst_prev) begin
                    chk(chnl == 3'(m_conv_idx % NCH), "chnl_at_convst",
                        chnl, m_conv_idx % NCH);
                end
                if (n_convst && !m_convst_prev) begin
                    m_convst_rise_cyc = cyc;
                    if (eoc_mode == 0) m_wait = $urandom_range(5, 1);
                    else if (eoc_mode == 1) m_wait = eoc_fix;
                    else m_wait = 0;
                end
                if (m_wait > 0) begin
                    m_wait--;
                    if (m_wait == 0) n_eoc = 1'b0;
                end
                if (!n_rd && m_rd_prev) begin
                    n_eoc = 1'b1;
                    adc_in = DW'($urandom);
                end
                if (n_rd && !m_rd_prev) begin
                    m_frame[(m_conv_idx % NCH)*DW +: DW] = adc_in;
                    m_conv_idx++;
                    if (m_conv_idx % NCH == 0) begin
                        frame_no = m_conv_idx / NCH - 1;
                        if (frame_no % (int'(decim) + 1) == int'(decim)) begin
                            exp_q.push_back('{addr: AW'(m_wr_cnt % DEPTH), data: m_frame});
                            m_wr_cnt++;
                        end
                    end
                end
                m_convst_prev = n_convst;
                m_rd_prev     = n_rd;
                m_busy_prev   = busy;
            end
        end
    end

    // Monitor: every wren pops one expected write and compares it.
    initial begin : monitor
        exp_t e;
        logic wren_prev;
        logic busy_prev;
        int   last_wr_cyc;
        wren_prev = 1'b0; busy_prev = 1'b0; last_wr_cyc = -1;
        forever begin
            @(negedge clk);
            if (busy && !busy_prev) last_wr_cyc = -1;
            if (!reset && wren) begin
                n_wr++;
                chk(!wren_prev, "wren_single_cycle", wren_prev, 0);
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_wren", w_addr, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk(w_addr == e.addr, "w_addr", w_addr, e.addr);
                    chk(w_data == e.data, "w_data", w_data, e.data);
                end
                if (spacing_on != 0 && last_wr_cyc >= 0) begin
                    chk(cyc - last_wr_cyc == spacing_exp, "wren_spacing",
                        cyc - last_wr_cyc, spacing_exp);
                end
                last_wr_cyc = cyc;
            end
            wren_prev = wren;
            busy_prev = busy;
        end
    end

    task automatic arm(input logic cont, input logic [3:0] dec);
        @(negedge clk);
        continuous = cont;
        decim = dec;
        start = 1'b1;
        @(negedge clk);
        chk(busy == 1'b1, "busy_after_arm", busy, 1);
        chk(eoc_err == 1'b0, "eoc_err_cleared", eoc_err, 0);
    endtask

    task automatic wait_done(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk(done == 1'b1, "done_reached", done, 1);
    endtask

    task automatic run_single(input logic [3:0] dec, input int bound);
        int base;
        base = n_wr;
        arm(1'b0, dec);
        wait_done(bound);
        repeat (3) @(negedge clk);
        chk(n_wr - base == DEPTH, "write_count", n_wr - base, DEPTH);
        chk(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
        chk(done == 1'b1, "done_held", done, 1);
        chk(busy == 1'b0, "busy_low_in_done", busy, 0);
        chk(w_addr == '0, "w_addr_wrapped", w_addr, 0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk(done == 1'b0, "idle_after_start_low", done, 0);
    endtask

    initial begin : stimulus
        int base;
        int i;
        reset = 1'b1; start = 1'b0; continuous = 1'b0; decim = 4'd0;
        repeat (3) @(negedge clk);
        chk(n_convst && n_cs && n_rd, "reset_strobes", {n_convst, n_cs, n_rd}, 3'b111);
        chk(chnl == 3'd0, "reset_chnl", chnl, 0);
        chk(w_addr == '0 && w_data == '0, "reset_addr_data", w_data, 0);
        chk(!wren && !busy && !done, "reset_ctrl", {wren, busy, done}, 0);
        chk(!overrun && !eoc_err, "reset_flags", {overrun, eoc_err}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk(!busy && !done, "idle_after_reset", {busy, done}, 0);

        // Single-shot, random EOC delays
        eoc_mode = 0;
        run_single(4'd0, DEPTH*FP + 200);
        chk(overrun == 1'b0, "no_overrun_single", overrun, 0);

        // Decimation by 4 with fixed EOC: writes exactly 4 frame periods apart
        eoc_mode = 1; eoc_fix = 3;
        spacing_on = 1; spacing_exp = 4*FP;
        run_single(4'd3, 4*DEPTH*FP + 400);
        chk(overrun == 1'b0, "no_overrun_decim", overrun, 0);

        // Frame longer than the period: every other tick is dropped
        eoc_mode = 1; eoc_fix = 15;
        spacing_on = 1; spacing_exp = 2*FP;
        run_single(4'd0, 2*DEPTH*FP + 400);
        chk(overrun == 1'b1, "overrun_set", overrun, 1);
        spacing_on = 0;

        // Continuous ring capture stopped at a random point after wrapping twice
        eoc_mode = 0;
        base = n_wr;
        arm(1'b1, 4'd0);
        for (i = 0; i < 50*FP; i++) begin
            @(negedge clk);
            if (n_wr - base >= 2*DEPTH + 5) break;
        end
        chk(n_wr - base >= 2*DEPTH + 5, "continuous_wraps", n_wr - base, 2*DEPTH + 5);
        repeat ($urandom_range(FP - 1, 0)) @(negedge clk);
        start = 1'b0;
        wait_done(3*FP);
        repeat (2) @(negedge clk);
        chk(busy == 1'b0, "busy_low_after_stop", busy, 0);
        chk(exp_q.size() == 0, "last_frame_written", exp_q.size(), 0);
        base = n_wr;
        repeat (4*FP) @(negedge clk);
        chk(n_wr == base, "no_wren_after_stop", n_wr - base, 0);

        // EOC stuck high: timeout, no writes, strobes idle
        eoc_mode = 2;
        base = n_wr;
        arm(1'b0, 4'd0);
        for (i = 0; i < 2*TO; i++) begin
            @(negedge clk);
            if (eoc_err) break;
        end
        chk(eoc_err == 1'b1, "eoc_err_set", eoc_err, 1);
        chk(cyc - m_convst_rise_cyc == TO, "eoc_timeout_cycles", cyc - m_convst_rise_cyc, TO);
        repeat (2) @(negedge clk);
        chk(done == 1'b1 && busy == 1'b0, "done_after_timeout", {done, busy}, 2'b10);
        chk(n_wr == base, "no_wren_on_timeout", n_wr - base, 0);
        chk(n_convst && n_cs && n_rd, "strobes_idle_timeout", {n_convst, n_cs, n_rd}, 3'b111);
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during the read of channel 2, then a clean restart
        eoc_mode = 0;
        arm(1'b0, 4'd0);
        for (i = 0; i < 4*FP; i++) begin
            @(negedge clk);
            if (!n_rd && chnl == 3'd2) break;
        end
        chk(!n_rd && chnl == 3'd2, "reached_read_ch2", {n_rd, chnl}, 3'd2);
        #2 reset = 1'b1;
        #1;
        chk(n_convst && n_cs && n_rd, "async_reset_strobes", {n_convst, n_cs, n_rd}, 3'b111);
        chk(!busy && !done && !wren, "async_reset_ctrl", {busy, done, wren}, 0);
        chk(w_addr == '0 && w_data == '0 && chnl == 3'd0, "async_reset_data", w_data, 0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        run_single(4'd0, DEPTH*FP + 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
- Parametrised successor to the fixed 8-bit, 4-channel, 512-deep ADC capture block.
- Drives the parallel ADC handshake directly: chnl, n_convst, n_eoc, n_cs, n_rd.
- Scans NUM_CH channels per frame at a programmable frame rate and writes each packed frame to a DEPTH-entry sample RAM.
- Adds continuous ring capture, an EOC timeout, overrun detection and a decimation option; feeds the beamforming RAM in the mic-array datapath.

Parameters:
- DATA_W, 8, ADC sample width.
- NUM_CH, 4, channels scanned per frame (1..8); chnl width is 3.
- ADDR_W, 9, RAM address width; DEPTH = 2**ADDR_W frames.
- FRAME_PERIOD, 1250, clk cycles between frame starts (must be >= 2).
- CONVST_CYC, 2, n_convst low-pulse width in clk cycles.
- RD_CYC, 3, n_rd low width in clk cycles; data is latched on the last cycle.
- EOC_TIMEOUT, 255, maximum clk cycles to wait for n_eoc low.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, async active-high reset.
- chnl, output, 3, ADC channel select.
- n_convst, output, 1, active-low conversion start.
- n_eoc, input, 1, active-low end of conversion (pre-synchronised externally).
- n_cs, output, 1, active-low chip select.
- n_rd, output, 1, active-low read strobe.
- adc_in, input, DATA_W, ADC data bus.
- start, input, 1, level; rising edge arms a capture; low stops continuous mode.
- continuous, input, 1, sampled at arm: 0 = single-shot, 1 = ring.
- decim, input, 4, sampled at arm: write every (decim+1)th frame.
- w_addr, output, ADDR_W, RAM write address.
- w_data, output, NUM_CH*DATA_W, packed frame; ch0 in the LSBs.
- wren, output, 1, one-cycle write strobe.
- busy, output, 1, high from arm until DONE/IDLE.
- done, output, 1, high in DONE.
- overrun, output, 1, sticky; cleared on arm.
- eoc_err, output, 1, sticky; cleared on arm.

Behaviour:
- Reset (async): state IDLE, chnl=0, n_convst=n_cs=n_rd=1, w_addr=0, w_data=0, wren=0, busy=done=overrun=eoc_err=0, frame timer=0, decimation counter=0.
- Arm: start rising edge (registered start prev=0, start=1) in IDLE.
  - Latch continuous and decim; clear w_addr, overrun, eoc_err and counters.
  - Go to CONV with chnl=0; the frame timer restarts.
- Frame timer: free-runs modulo FRAME_PERIOD while busy; tick on wrap.
- FSM states:
  - IDLE
  - CONV: n_convst low for CONVST_CYC cycles, chnl held.
  - WAIT_EOC: counts cycles. On n_eoc=0, go to READ. If the count reaches EOC_TIMEOUT, set eoc_err and go to DONE without writing.
  - READ: n_cs and n_rd low for RD_CYC cycles; adc_in is latched into lane chnl on the final cycle; then n_cs=n_rd=1.
  - NEXT: if chnl==NUM_CH-1, go to WRITE; else chnl+1 and go to CONV.
  - WRITE: if the decimation counter == decim, assert wren for exactly 1 cycle with the current w_addr/w_data and clear the counter; else increment the counter with no write. Go to WAIT_TICK.
  - WAIT_TICK: wait for the tick, then chnl=0 and go to CONV.
  - DONE: done=1. Go to IDLE when start=0.
- Address advance: w_addr increments the cycle after each wren and wraps from DEPTH-1 to 0.
- Single-shot: the write at w_addr=DEPTH-1 goes to DONE instead of WAIT_TICK; exactly DEPTH writes occur.
- Continuous: wraps indefinitely. If start=0 is seen in WAIT_TICK, go to DONE; an in-progress frame always completes and is written first.
- Overrun: a tick arriving in any state other than WAIT_TICK sets overrun. That tick is dropped, and the next frame begins on the following tick.
- Data stability: w_data lanes update only in READ, so w_data is stable during wren.
- start held high through DONE: stays in DONE with no re-arm. A new rising edge is required after returning to IDLE.
- Reset mid-frame: immediate return to reset values; the ADC strobes are deasserted asynchronously.
- Latency: first wren occurs NUM_CH*(CONVST_CYC + t_eoc + RD_CYC + 2) + 1 cycles after arm.

Test Plan:
- Single-shot, NUM_CH=4, ADC model returns {frame[7:0] + ch} with 10-cycle EOC -> exactly 512 wren pulses, w_addr 0..511, w_data lane k = addr+k, then done=1, busy=0.
- Continuous with decim=0, start dropped at frame 700 -> w_addr wraps 511 -> 0, the last frame is written at addr 187 or 188, then done=1 and no further wren.
- decim=3 single-shot -> wren on frames 3, 7, 11, ...; 512 writes over 2048 frames; spacing = 4*FRAME_PERIOD.
- FRAME_PERIOD=40 with 15-cycle EOC, NUM_CH=4 -> overrun=1 after the first frame, ticks skipped, data still correct per frame.
- n_eoc stuck high -> eoc_err=1 at 255 cycles after n_convst rises, state DONE, no wren, strobes idle high.
- Reset asserted in READ of ch2 -> n_cs=n_rd=n_convst=1 and all outputs reset within the same cycle; a new arm restarts at w_addr=0.
